// File: rtl/shift_rot_pipe.sv
// shift_rot_pipe: pipelined barrel shifter/rotator, one registered stage per amount bit.
// Define SHIFT_ARITH_EN to make op 11 an arithmetic (sign-filling) right shift.
module shift_rot_pipe #(
  parameter int WIDTH = 16,
  localparam int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [LOG2W-1:0] in_amt_i,
  input  logic [1:0]       in_op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_zero_o
);
`ifdef SHIFT_ARITH_EN
  localparam bit ARITH = 1'b1;
`else
  localparam bit ARITH = 1'b0;
`endif
  logic adv;
  assign adv = !out_valid_o | out_ready_i;
  assign in_ready_o = adv;
  for (genvar k = 0; k < LOG2W; k++) begin : g_st
    localparam int S = 1 << k;
    logic [WIDTH-1:0] din, sh, data_d, data_q;
    logic [LOG2W-k-1:0] ain;
    logic [1:0] oin;
    logic vin, vld_q, fill;
    if (k == 0) begin : g_src
      assign din = in_data_i;
      assign ain = in_amt_i;
      assign oin = in_op_i;
      assign vin = in_valid_i;
    end else begin : g_src
      assign din = g_st[k-1].data_q;
      assign ain = g_st[k-1].g_ctl.amt_q;
      assign oin = g_st[k-1].g_ctl.op_q;
      assign vin = g_st[k-1].vld_q;
    end
    assign fill = ARITH & din[WIDTH-1];
    assign sh = oin == 2'b00 ? {din[WIDTH-S-1:0], din[WIDTH-1:WIDTH-S]} :
                oin == 2'b01 ? {din[WIDTH-S-1:0], {S{1'b0}}} :
                oin == 2'b10 ? {din[S-1:0], din[WIDTH-1:S]} :
                               {{S{fill}}, din[WIDTH-1:S]};
    assign data_d = ain[0] ? sh : din;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
        vld_q  <= 1'b0;
      end else if (adv) begin
        data_q <= data_d;
        vld_q  <= vin;
      end
    end
    // Each stage consumes the amount LSB and hands the remaining bits onward.
    if (k < LOG2W - 1) begin : g_ctl
      logic [LOG2W-k-2:0] amt_q;
      logic [1:0] op_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          amt_q <= '0;
          op_q  <= '0;
        end else if (adv) begin
          amt_q <= ain[LOG2W-k-1:1];
          op_q  <= oin;
        end
      end
    end
  end
  assign out_valid_o = g_st[LOG2W-1].vld_q;
  assign out_data_o  = g_st[LOG2W-1].data_q;
  assign out_zero_o  = ~|out_data_o;
endmodule

// File: tb/tb_shift_rot_pipe.sv
// tb_shift_rot_pipe: scoreboard bench for shift_rot_pipe, directed plus randomized traffic.
module tb_shift_rot_pipe;
  localparam int W = 16;
  localparam int L = 4;
  logic clk = 1'b0, rst_n = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b1;
  logic [W-1:0] in_data_i = '0;
  logic [L-1:0] in_amt_i = '0;
  logic [1:0] in_op_i = '0;
  logic in_ready_o, out_valid_o, out_zero_o;
  logic [W-1:0] out_data_o;
  int tests = 0, fails = 0, cyc = 0;
  logic [W-1:0] exp_q[$];
  int pop_t[$];

  shift_rot_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .in_amt_i(in_amt_i), .in_op_i(in_op_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_zero_o(out_zero_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: rotations via a doubled word, shifts via plain operators.
  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] d, input int a);
    logic [2*W-1:0] dd;
    dd = {d, d};
    case (op)
      2'b00: begin dd = dd << a; return dd[2*W-1:W]; end
      2'b01: return d << a;
      2'b10: begin dd = dd >> a; return dd[W-1:0]; end
      default: begin
`ifdef SHIFT_ARITH_EN
        return $signed(d) >>> a;
`else
        return d >> a;
`endif
      end
    endcase
  endfunction

  task automatic send(input logic [1:0] op, input logic [W-1:0] d, input int a, input logic [W-1:0] e);
    int n;
    n = 0;
    @(negedge clk);
    in_valid_i = 1'b1;
    in_op_i = op;
    in_data_i = d;
    in_amt_i = L'(a);
    #1;
    while (!in_ready_o && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("accept_timeout", 0, 1);
    exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic latency(input string name);
    int cnt;
    cnt = 1;
    while (!out_valid_o && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk(name, cnt, L);
  endtask

  always begin : mon
    logic stall;
    logic [W-1:0] held, e;
    stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst_n) stall = 1'b0;
      else begin
        if (stall) begin
          chk("hold_valid", out_valid_o, 1);
          chk("hold_data", out_data_o, held);
        end
        if (out_valid_o && out_ready_i) begin
          if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("data", out_data_o, e);
            chk("zero", out_zero_o, e == '0);
            pop_t.push_back(cyc);
          end
        end
        stall = out_valid_o && !out_ready_i;
        held = out_data_o;
      end
    end
  end

  initial begin
    logic seen;
    logic [1:0] op;
    logic [W-1:0] d;
    int a;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_out_data", out_data_o, 0);
    chk("rst_out_zero", out_zero_o, 1);
    chk("rst_in_ready", in_ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    send(2'b00, 16'h8001, 1, 16'h0003);
    latency("latency_first");
    drain();

    pop_t.delete();
    send(2'b01, 16'h8001, 4, 16'h0010);
    send(2'b10, 16'h0001, 1, 16'h8000);
    send(2'b11, 16'h8000, 15, 16'h0001);
    send(2'b01, 16'hFFFF, 0, 16'hFFFF);
    send(2'b01, 16'h0001, 15, 16'h8000);
    send(2'b01, 16'h8000, 1, 16'h0000);
    drain();
    chk("b2b_count", pop_t.size(), 6);
    for (int i = 1; i < pop_t.size(); i++) chk("b2b_consecutive", pop_t[i] - pop_t[i-1], 1);

    pop_t.delete();
    fork
      begin
        int n;
        n = 0;
        while (!out_valid_o && n < 50) begin
          @(negedge clk);
          n++;
        end
        out_ready_i = 1'b0;
        #1 chk("bp_in_ready", in_ready_o, 0);
        repeat (5) @(negedge clk);
        out_ready_i = 1'b1;
      end
    join_none
    for (int i = 0; i < 6; i++) begin
      op = 2'($urandom_range(0, 3));
      d = W'($urandom);
      a = $urandom_range(0, W - 1);
      send(op, d, a, model(op, d, a));
    end
    drain();
    chk("bp_count", pop_t.size(), 6);

    pop_t.delete();
    send(2'b10, 16'h1234, 4, 16'h4123);
    @(negedge clk);
    send(2'b10, 16'h1234, 8, 16'h3412);
    drain();
    chk("bubble_count", pop_t.size(), 2);
    if (pop_t.size() == 2) chk("bubble_gap", pop_t[1] - pop_t[0], 2);

    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send(2'b00, W'($urandom), i + 1, 16'h0);
    @(posedge clk);
    #1 chk("rmf_pre_valid", out_valid_o, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rmf_valid", out_valid_o, 0);
    chk("rmf_zero", out_zero_o, 1);
    exp_q.delete();
    out_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid_o) seen = 1'b1;
    end
    chk("rmf_no_stale", seen, 0);
    send(2'b01, 16'h0001, 3, 16'h0008);
    latency("latency_after_reset");
    drain();

`ifdef SHIFT_ARITH_EN
    send(2'b11, 16'h8000, 3, 16'hF000);
`else
    send(2'b11, 16'h8000, 3, 16'h1000);
`endif
    drain();

    fork
      begin
        repeat (300) begin
          @(negedge clk);
          out_ready_i = $urandom_range(0, 3) != 0;
        end
        out_ready_i = 1'b1;
      end
    join_none
    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      d = W'($urandom);
      a = $urandom_range(0, W - 1);
      send(op, d, a, model(op, d, a));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
